mult_driver: RTL and testbench

MULT_DRIVER -- requirements
Module: mult_driver

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_driver.sv | 126 ++++++++++++
 tb/tb_mult_driver.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier driver.
// State encoding, default operand width and WAIT timeout limit.
package mult_pkg;

  localparam int W_DEF    = 5;
  localparam int TO_LIMIT = 31;
  localparam int TO_W     = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND_Y,
    S_SEND_X,
    S_WAIT,
    S_CAP_HI,
    S_CAP_LO,
    S_OUT
  } state_t;

endpackage

// File: rtl/mult_driver.sv
// Sequences one operand pair through a serial multiplier and returns {hi,lo}.
// Define MULT_DRIVER_TIMEOUT_EN to bound the WAIT state and flag out_err.
module mult_driver
  import mult_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_x,
  input  logic [W-1:0]   in_y,
  output logic           m_start,
  output logic [W-1:0]   m_data,
  input  logic           m_done,
  input  logic [W-1:0]   m_data_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_prod,
  output logic           out_err
);

  state_t       st;
  logic [W-1:0] x_q;
  logic [W-1:0] y_q;
  logic [W-1:0] hi_q;
  logic [W-1:0] lo_q;

`ifdef MULT_DRIVER_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      st        <= S_IDLE;
      in_ready  <= 1'b1;
      m_start   <= 1'b0;
      m_data    <= '0;
      out_valid <= 1'b0;
      out_prod  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULT_DRIVER_TIMEOUT_EN
      to_cnt    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      unique case (st)
        S_IDLE: begin
          if (in_valid) begin
            x_q      <= in_x;
            y_q      <= in_y;
            in_ready <= 1'b0;
            m_start  <= 1'b1;
            st       <= S_START;
          end
        end
        S_START: begin
          m_start <= 1'b0;
          m_data  <= y_q;
          st      <= S_SEND_Y;
        end
        S_SEND_Y: begin
          m_data <= x_q;
          st     <= S_SEND_X;
        end
        S_SEND_X: begin
          m_data <= '0;
          st     <= S_WAIT;
`ifdef MULT_DRIVER_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        S_WAIT: begin
          // high half is on the bus in the same cycle as m_done
          if (m_done) begin
            hi_q <= m_data_out;
            st   <= S_CAP_HI;
          end
`ifdef MULT_DRIVER_TIMEOUT_EN
          else if (to_cnt == TO_W'(TO_LIMIT - 1)) begin
            out_prod  <= '0;
            err_q     <= 1'b1;
            out_valid <= 1'b1;
            st        <= S_OUT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        S_CAP_HI: begin
          lo_q <= m_data_out;
          st   <= S_CAP_LO;
        end
        S_CAP_LO: begin
          out_prod  <= {hi_q, lo_q};
          out_valid <= 1'b1;
`ifdef MULT_DRIVER_TIMEOUT_EN
          err_q     <= 1'b0;
`endif
          st        <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef MULT_DRIVER_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            st        <= S_IDLE;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_driver.sv
// Directed bench for mult_driver with a timeline-based reference model.
// The bench plays the multiplier side (m_done / m_data_out).
module tb_mult_driver;

  localparam int W = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_x;
  logic [W-1:0]   in_y;
  logic           m_start;
  logic [W-1:0]   m_data;
  logic           m_done;
  logic [W-1:0]   m_data_out;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_prod;
  logic           out_err;

  int n_cmp = 0;
  int n_bad = 0;

  mult_driver #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .m_start    (m_start),
    .m_data     (m_data),
    .m_done     (m_done),
    .m_data_out (m_data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_prod   (out_prod),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is a timeline of edges counted from
  // its accept edge a; the done edge e anchors the capture and OUT entry.
  bit             model_on = 0;
  bit             busy = 0;
  bit             mo = 0;
  bit             eerr = 0;
  int             cyc = 0;
  int             a = 0;
  int             e = -1;
  logic [W-1:0]   xm = '0;
  logic [W-1:0]   ym = '0;
  logic [W-1:0]   hm = '0;
  logic [W-1:0]   lm = '0;
  logic [2*W-1:0] eprod = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst) begin
      busy     = 0;
      mo       = 0;
      model_on = 1;
    end else if (!busy) begin
      if (in_valid) begin
        busy = 1;
        mo   = 0;
        a    = cyc;
        e    = -1;
        xm   = in_x;
        ym   = in_y;
      end
    end else if (mo) begin
      if (out_ready) begin
        busy = 0;
        mo   = 0;
      end
    end else if (e < 0) begin
      if (cyc >= a + 4 && m_done) begin
        e  = cyc;
        hm = m_data_out;
      end
`ifdef MULT_DRIVER_TIMEOUT_EN
      else if (cyc == a + 34) begin
        mo    = 1;
        eprod = '0;
        eerr  = 1;
      end
`endif
    end else if (cyc == e + 1) begin
      lm = m_data_out;
    end else if (cyc == e + 2) begin
      mo    = 1;
      eprod = {hm, lm};
      eerr  = 0;
    end
  end

  function automatic logic [W-1:0] exp_md();
    if (busy && cyc == a + 1) return ym;
    if (busy && cyc == a + 2) return xm;
    return '0;
  endfunction

  initial forever begin
    @(negedge clk);
    if (model_on) begin
      chk("in_ready", 32'(in_ready), 32'(!busy));
      chk("m_start", 32'(m_start), 32'(busy && !mo && cyc == a));
      chk("m_data", 32'(m_data), 32'(exp_md()));
      chk("out_valid", 32'(out_valid), 32'(mo));
      if (mo) begin
        chk("out_prod", 32'(out_prod), 32'(eprod));
        chk("out_err", 32'(out_err), 32'(eerr));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit keep);
    int n = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready=%0b want 1", in_ready);
    end
    tick();
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic to_wait();
    repeat (3) tick();
  endtask

  task automatic done_after(input int n, input logic [W-1:0] hi,
                            input logic [W-1:0] lo);
    repeat (n - 1) tick();
    m_done     = 1'b1;
    m_data_out = hi;
    tick();
    m_done     = 1'b0;
    m_data_out = lo;
    tick();
    m_data_out = '0;
    tick();
  endtask

  task automatic drain(input int nstall);
    repeat (nstall) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_x       = '0;
    in_y       = '0;
    m_done     = 1'b0;
    m_data_out = '0;
    out_ready  = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_m_start", 32'(m_start), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_prod", 32'(out_prod), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    rst = 1'b1;
    tick();

    // 3 * -2 = -6
    accept(5'd3, 5'b11110, 0);
    to_wait();
    done_after(6, 5'b11111, 5'b11010);
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_prod", 32'(out_prod), 32'h3FA);
    chk("basic_err", 32'(out_err), 32'd0);
    drain(0);

    accept(5'h0A, 5'h13, 0);
    chk("seq_start", 32'(m_start), 32'd1);
    chk("seq_data0", 32'(m_data), 32'd0);
    tick();
    chk("seq_start_off", 32'(m_start), 32'd0);
    chk("seq_data_y", 32'(m_data), 32'h13);
    tick();
    chk("seq_data_x", 32'(m_data), 32'h0A);
    tick();
    chk("seq_data_end", 32'(m_data), 32'd0);
    done_after(1, 5'b10000, 5'b01111);
    chk("seq_prod", 32'(out_prod), 32'h20F);
    drain(0);

    accept(5'd3, 5'd2, 0);
    to_wait();
    done_after(3, 5'b00000, 5'b00110);
    in_valid = 1'b1;
    in_x     = 5'd7;
    in_y     = 5'd7;
    for (int i = 0; i < 4; i++) begin
      chk("bp_prod", 32'(out_prod), 32'h006);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("bp_idle", 32'(in_ready), 32'd1);
    chk("bp_valid_off", 32'(out_valid), 32'd0);

    accept(5'd9, 5'd4, 0);
    to_wait();
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_prod", 32'(out_prod), 32'd0);
    chk("mid_rst_start", 32'(m_start), 32'd0);
    chk("mid_rst_data", 32'(m_data), 32'd0);
    m_done     = 1'b1;
    m_data_out = 5'h1F;
    tick();
    m_done     = 1'b0;
    m_data_out = '0;
    tick();
    chk("late_done_valid", 32'(out_valid), 32'd0);
    chk("late_done_ready", 32'(in_ready), 32'd1);
    chk("late_done_start", 32'(m_start), 32'd0);

    accept(5'd6, 5'd5, 0);
    to_wait();
`ifdef MULT_DRIVER_TIMEOUT_EN
    repeat (30) tick();
    chk("to_not_yet", 32'(out_valid), 32'd0);
    tick();
    chk("to_valid", 32'(out_valid), 32'd1);
    chk("to_err", 32'(out_err), 32'd1);
    chk("to_prod", 32'(out_prod), 32'd0);
    drain(0);
`else
    repeat (97) tick();
    chk("wait100_valid", 32'(out_valid), 32'd0);
    chk("wait100_ready", 32'(in_ready), 32'd0);
    done_after(1, 5'b00000, 5'b11110);
    chk("wait100_prod", 32'(out_prod), 32'h01E);
    chk("wait100_err", 32'(out_err), 32'd0);
    drain(0);
`endif

    // 2 * -3 = -6, then a second pair already waiting on in_valid
    accept(5'd2, 5'b11101, 1);
    in_x = 5'h04;
    in_y = 5'h04;
    to_wait();
    done_after(2, 5'b11111, 5'b11010);
    chk("b2b_prod1", 32'(out_prod), 32'h3FA);
    chk("b2b_hold", 32'(in_ready), 32'd0);
    drain(1);
    chk("b2b_idle", 32'(in_ready), 32'd1);
    chk("b2b_no_start", 32'(m_start), 32'd0);
    tick();
    chk("b2b_start2", 32'(m_start), 32'd1);
    chk("b2b_busy2", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    to_wait();
    done_after(1, 5'b00000, 5'b10000);
    chk("b2b_prod2", 32'(out_prod), 32'h010);
    drain(0);

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
